// File: rtl/led_pwm_multi_pkg.sv
// led_pwm_multi_pkg: register map, mode encodings and field positions for the LED PWM block
package led_pwm_multi_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_PWM     = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam int REG_CH0      = 'h00;
    localparam int REG_CTRL     = 'h40;
    localparam int REG_PRESCALE = 'h44;
    localparam int REG_BLINK    = 'h48;

    localparam int MODE_LSB = 16;
    localparam int INV_BIT  = 24;
    localparam int EN_BIT   = 0;

    function automatic logic [4:0] reg_idx(input int offs);
        return 5'(offs >> 2);
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel with glitch-free settings latch, mode mux and registered output
module led_pwm_channel
    import led_pwm_multi_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                period_end,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [1:0]          mode,
    input  logic                inv,
    input  logic [PWM_BITS-1:0] pwm_ctr,
    input  logic [PWM_BITS-1:0] level,
    input  logic                blink_phase,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0]   duty_a;
    mode_e                 mode_a;
    logic                  inv_a;
    logic [2*PWM_BITS-1:0] prod;
    logic [PWM_BITS-1:0]   eff_duty;
    logic                  raw;

    // active settings follow the shadow copy only at period boundaries, or continuously while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_a <= '0;
            mode_a <= MODE_OFF;
            inv_a  <= 1'b0;
        end else if (!en || period_end) begin
            duty_a <= duty;
            mode_a <= mode_e'(mode);
            inv_a  <= inv;
        end
    end

    // mode mux; breathe scales the duty by the shared brightness level
    always_comb begin
        prod     = {{PWM_BITS{1'b0}}, duty_a} * {{PWM_BITS{1'b0}}, level};
        eff_duty = PWM_BITS'(prod >> PWM_BITS);
        raw      = (mode_a == MODE_PWM)     ? (pwm_ctr < duty_a) :
                   (mode_a == MODE_BLINK)   ? ((pwm_ctr < duty_a) & blink_phase) :
                   (mode_a == MODE_BREATHE) ? (pwm_ctr < eff_duty) : 1'b0;
    end

    // pin register; a disabled block rests each pin at its polarity level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_out <= 1'b0;
        else        pwm_out <= en ? (raw ^ inv_a) : inv_a;
    end

endmodule

// File: rtl/led_pwm_multi.sv
// led_pwm_multi: APB-programmable N-channel LED PWM with off/pwm/blink/breathe modes
module led_pwm_multi
    import led_pwm_multi_pkg::*;
#(
    parameter int N_CHANNELS    = 3,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 8,
    parameter int W_ADDR        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  apbs_psel,
    input  logic                  apbs_penable,
    input  logic                  apbs_pwrite,
    input  logic [W_ADDR-1:0]     apbs_paddr,
    input  logic [31:0]           apbs_pwdata,
    output logic [31:0]           apbs_prdata,
    output logic                  apbs_pready,
    output logic                  apbs_pslverr,
    output logic [N_CHANNELS-1:0] pwm_out
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    logic                     wr;
    logic [4:0]               idx;
    logic [PWM_BITS-1:0]      sh_duty [N_CHANNELS];
    logic [1:0]               sh_mode [N_CHANNELS];
    logic [N_CHANNELS-1:0]    sh_inv;
    logic                     en;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [PRESCALE_BITS-1:0] presc_ctr;
    logic [15:0]              blink;
    logic [15:0]              blink_ctr;
    logic                     blink_phase;
    logic [PWM_BITS-1:0]      pwm_ctr;
    logic [PWM_BITS-1:0]      level;
    logic                     dir;
    logic                     tick;
    logic                     period_end;
    logic                     step_dn;
    logic                     unused_apb;

    assign wr           = apbs_psel & apbs_penable & apbs_pwrite;
    assign idx          = apbs_paddr[6:2];
    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;
    assign unused_apb   = ^{apbs_paddr, apbs_pwdata};

    // >= rather than == so lowering PRESCALE below the running count still ticks at once
    assign tick       = en & (presc_ctr >= prescale);
    assign period_end = tick & (pwm_ctr == PWM_MAX);
    assign step_dn    = dir ? (level != '0) : (level == PWM_MAX);

    // register file writes into the shadow copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                sh_duty[i] <= '0;
                sh_mode[i] <= '0;
            end
            sh_inv   <= '0;
            en       <= 1'b0;
            prescale <= '0;
            blink    <= '0;
        end else if (wr) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (idx == reg_idx(REG_CH0) + 5'(i)) begin
                    sh_duty[i] <= apbs_pwdata[PWM_BITS-1:0];
                    sh_mode[i] <= apbs_pwdata[MODE_LSB+1:MODE_LSB];
                    sh_inv[i]  <= apbs_pwdata[INV_BIT];
                end
            end
            if (idx == reg_idx(REG_CTRL))     en       <= apbs_pwdata[EN_BIT];
            if (idx == reg_idx(REG_PRESCALE)) prescale <= apbs_pwdata[PRESCALE_BITS-1:0];
            if (idx == reg_idx(REG_BLINK))    blink    <= apbs_pwdata[15:0];
        end
    end

    // combinational read-back of shadow registers; absent channels and holes read zero
    always_comb begin
        apbs_prdata = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (idx == reg_idx(REG_CH0) + 5'(i))
                apbs_prdata = 32'(sh_duty[i]) | (32'(sh_mode[i]) << MODE_LSB) | (32'(sh_inv[i]) << INV_BIT);
        end
        if (idx == reg_idx(REG_CTRL))     apbs_prdata = 32'(en) << EN_BIT;
        if (idx == reg_idx(REG_PRESCALE)) apbs_prdata = 32'(prescale);
        if (idx == reg_idx(REG_BLINK))    apbs_prdata = 32'(blink);
    end

    // shared prescaler and PWM period counter, parked at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_ctr <= '0;
            pwm_ctr   <= '0;
        end else if (!en) begin
            presc_ctr <= '0;
            pwm_ctr   <= '0;
        end else begin
            presc_ctr <= tick ? '0 : presc_ctr + 1'b1;
            if (tick) pwm_ctr <= pwm_ctr + 1'b1;
        end
    end

    // blink phase toggles after BLINK+1 whole periods
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_ctr   <= '0;
            blink_phase <= 1'b0;
        end else if (!en) begin
            blink_ctr   <= '0;
            blink_phase <= 1'b0;
        end else if (period_end) begin
            blink_ctr   <= (blink_ctr >= blink) ? '0 : blink_ctr + 1'b1;
            blink_phase <= blink_phase ^ (blink_ctr >= blink);
        end
    end

    // breathe level walks a 0..max..0 triangle, one step per period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            dir   <= 1'b0;
        end else if (!en) begin
            level <= '0;
            dir   <= 1'b0;
        end else if (period_end) begin
            level <= step_dn ? level - 1'b1 : level + 1'b1;
            dir   <= step_dn;
        end
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .period_end  (period_end),
            .duty        (sh_duty[c]),
            .mode        (sh_mode[c]),
            .inv         (sh_inv[c]),
            .pwm_ctr     (pwm_ctr),
            .level       (level),
            .blink_phase (blink_phase),
            .pwm_out     (pwm_out[c])
        );
    end

endmodule

// File: tb/tb_led_pwm_multi.sv
// tb_led_pwm_multi: scoreboard bench for led_pwm_multi with directed vectors
module tb_led_pwm_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [2:0]  pwm_out;

    int    checks = 0;
    int    errors = 0;
    string name_q[$];
    int    exp_q[$];
    int    act_q[$];
    int    h0, h1, h2, r0, cnt, first;

    always #5 clk = ~clk;

    led_pwm_multi dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apbs_psel    (psel),
        .apbs_penable (penable),
        .apbs_pwrite  (pwrite),
        .apbs_paddr   (paddr),
        .apbs_pwdata  (pwdata),
        .apbs_prdata  (prdata),
        .apbs_pready  (pready),
        .apbs_pslverr (pslverr),
        .pwm_out      (pwm_out)
    );

    task automatic expect_val(input string n, input int v);
        name_q.push_back(n);
        exp_q.push_back(v);
    endtask

    task automatic observe(input int v);
        act_q.push_back(v);
    endtask

    // monitor: pairs each observation with the oldest outstanding expectation
    always @(negedge clk) begin
        while (act_q.size() != 0) begin
            int a;
            a = act_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_obs: got %0d with no expectation queued", a);
            end else begin
                string n;
                int e;
                n = name_q.pop_front();
                e = exp_q.pop_front();
                if (a != e) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d", n, a, e);
                end
            end
        end
    end

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, input string n, input int e);
        expect_val(n, e);
        expect_val({n, "_slverr"}, 0);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        observe(int'(prdata));
        observe(int'(pslverr));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // samples n consecutive negedges starting at the current one
    task automatic measure(input int n, output int c0, output int c1, output int c2, output int rises);
        logic p;
        c0 = 0; c1 = 0; c2 = 0; rises = 0; p = 1'b0;
        for (int i = 0; i < n; i++) begin
            c0 += int'(pwm_out[0]);
            c1 += int'(pwm_out[1]);
            c2 += int'(pwm_out[2]);
            if (pwm_out[0] && !p) rises++;
            p = pwm_out[0];
            @(negedge clk);
        end
    endtask

    function automatic int blink_exp(input int w);
        return ((w / 3) % 2) ? 255 : 0;
    endfunction

    function automatic int breathe_exp(input int w, input bit inv);
        int l, h;
        l = (w <= 255) ? w : 510 - w;
        h = (255 * l) >> 8;
        return inv ? 256 - h : h;
    endfunction

    task automatic window(input int w, input bit inv, input bit wr_inv);
        int c0, c1, c2, r;
        expect_val($sformatf("blink_w%0d", w), blink_exp(w));
        expect_val($sformatf("breathe_w%0d", w), breathe_exp(w, inv));
        expect_val($sformatf("ch0_w%0d", w), 192);
        fork
            measure(256, c0, c1, c2, r);
            begin
                if (wr_inv) begin
                    repeat (100) @(negedge clk);
                    apb_write(16'h0008, 32'h010300FF);
                end
            end
        join
        observe(c1);
        observe(c2);
        observe(c0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_val("rst_pwm", 0);
        observe(int'(pwm_out));
        apb_read(16'h0000, "rst_ch0", 0);
        apb_read(16'h0040, "rst_ctrl", 0);
        apb_read(16'h0048, "rst_blink", 0);

        apb_write(16'h0000, 32'h00010040);
        apb_write(16'h0040, 32'h1);
        @(negedge clk);
        expect_val("t1_pre", 0);
        observe(int'(pwm_out[0]));
        @(negedge clk);
        expect_val("t1_first", 1);
        observe(int'(pwm_out[0]));
        expect_val("t1_high", 64);
        expect_val("t1_rises", 1);
        measure(256, h0, h1, h2, r0);
        observe(h0);
        observe(r0);

        expect_val("t2_old_high", 64);
        expect_val("t2_old_rises", 1);
        fork
            measure(256, h0, h1, h2, r0);
            begin
                repeat (100) @(negedge clk);
                apb_write(16'h0000, 32'h000100C0);
            end
        join
        observe(h0);
        observe(r0);
        expect_val("t2_new_high", 192);
        expect_val("t2_new_rises", 1);
        measure(256, h0, h1, h2, r0);
        observe(h0);
        observe(r0);

        apb_write(16'h0040, 32'h0);
        apb_write(16'h0004, 32'h000200FF);
        apb_write(16'h0008, 32'h000300FF);
        apb_write(16'h0048, 32'h2);
        apb_write(16'h0040, 32'h1);
        @(negedge clk);
        @(negedge clk);
        for (int w = 0; w < 7; w++) window(w, 1'b0, 1'b0);
        repeat (247 * 256) @(negedge clk);
        for (int w = 254; w < 258; w++) window(w, 1'b0, 1'b0);
        window(258, 1'b0, 1'b1);
        window(259, 1'b1, 1'b0);

        apb_write(16'h0000, 32'h01010000);
        apb_write(16'h0040, 32'h0);
        repeat (4) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (pwm_out == 3'b101) cnt++;
            @(negedge clk);
        end
        expect_val("en0_steady", 16);
        observe(cnt);
        apb_write(16'h0040, 32'h1);
        repeat (50) @(negedge clk);
        expect_val("pre_rst_ch0", 1);
        observe(int'(pwm_out[0]));
        #3;
        rst_n = 1'b0;
        #1;
        expect_val("async_rst_pwm", 0);
        observe(int'(pwm_out));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apb_read(16'h0000, "post_rst_ch0", 0);
        apb_read(16'h0040, "post_rst_ctrl", 0);

        apb_write(16'h0000, 32'h00010001);
        apb_write(16'h0044, 32'd200);
        apb_write(16'h0040, 32'h1);
        repeat (97) @(posedge clk);
        apb_write(16'h0044, 32'd3);
        @(negedge clk);
        expect_val("t6_hold0", 1);
        observe(int'(pwm_out[0]));
        @(negedge clk);
        expect_val("t6_hold1", 1);
        observe(int'(pwm_out[0]));
        @(negedge clk);
        first = -1;
        cnt = 0;
        for (int i = 0; i < 1030; i++) begin
            if (pwm_out[0]) begin
                cnt++;
                if (first < 0) first = i;
            end
            @(negedge clk);
        end
        expect_val("t6_fall", 0);
        observe(first == 0 ? 1 : 0);
        expect_val("t6_next_high_at", 1020);
        observe(first);
        expect_val("t6_high_len", 4);
        observe(cnt);

        apb_read(16'h0044, "rd_prescale", 3);
        apb_read(16'h0060, "rd_unmapped", 0);
        apb_write(16'h000C, 32'hFFFFFFFF);
        apb_read(16'h000C, "rd_absent_ch3", 0);
        apb_write(16'h0048, 32'hABCD1234);
        apb_read(16'h0048, "rd_blink", 32'h1234);
        apb_write(16'h0004, 32'hFFFFFFFF);
        apb_read(16'h0004, "rd_ch1_fields", 32'h010300FF);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL pending_expectations: got %0d unmatched expected 0", exp_q.size());
            errors += exp_q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
